// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer sizing and the entry record, also consumed by rename.
// Module parameters default to these values and must agree with them.
package reorder_buffer_pkg;
   localparam int ROB_DEPTH = 16;
   localparam int PHYS_W    = 6;
   localparam int ARCH_W    = 5;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [PHYS_W-1:0] phys_rd;
      logic [PHYS_W-1:0] old_phys_rd;
      logic [ARCH_W-1:0] arch_rd;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer circular queue.
// Full and empty are told apart by count alone, since head == tail in both cases.
module rob_ptr_ctrl
#(
   parameter int DEPTH = reorder_buffer_pkg::ROB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             do_alloc,
   input  logic             do_retire,
   output logic [PTR_W-1:0] head,
   output logic [PTR_W-1:0] tail,
   output logic [PTR_W:0]   count
);
   import reorder_buffer_pkg::*;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // Power-of-two depth, so the pointer increment wraps on its own.
         if (do_alloc)  tail <= tail + PTR_W'(1);
         if (do_retire) head <= head + PTR_W'(1);
         case ({do_alloc, do_retire})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, mark done by physical tag,
// retire one done head entry per cycle and hand back its old physical register.
module reorder_buffer
#(
   parameter int ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
   parameter int PHYS_W    = reorder_buffer_pkg::PHYS_W,
   parameter int ARCH_W    = reorder_buffer_pkg::ARCH_W
)
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           alloc_valid,
   input  logic [PHYS_W-1:0]              alloc_phys_rd,
   input  logic [PHYS_W-1:0]              alloc_old_phys_rd,
   input  logic [ARCH_W-1:0]              alloc_arch_rd,
   output logic                           alloc_ready,
   output logic [$clog2(ROB_DEPTH)-1:0]   alloc_tag,
   input  logic                           complete_valid,
   input  logic [PHYS_W-1:0]              complete_phys_reg,
   output logic                           retire_valid,
   output logic [PHYS_W-1:0]              retire_phys_reg,
   output logic [ARCH_W-1:0]              retire_arch_reg,
   output logic                           rob_empty,
   output logic [$clog2(ROB_DEPTH):0]     rob_count
);
   import reorder_buffer_pkg::rob_entry_t;

   localparam int PTR_W = $clog2(ROB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             do_alloc;
   logic             do_retire;
   rob_entry_t       entries [ROB_DEPTH];

   // Ready looks only at registered occupancy, so a retire in the same cycle
   // never lets a full buffer take a new entry into the slot being freed.
   assign alloc_ready = (count < CNT_W'(ROB_DEPTH));
   assign rob_empty   = (count == '0);
   assign alloc_tag   = tail;
   assign rob_count   = count;
   assign do_alloc    = alloc_valid && alloc_ready;
   assign do_retire   = entries[head].valid && entries[head].done;

   rob_ptr_ctrl #(.DEPTH(ROB_DEPTH), .PTR_W(PTR_W)) u_ptr (
      .clk       (clk),
      .reset     (reset),
      .do_alloc  (do_alloc),
      .do_retire (do_retire),
      .head      (head),
      .tail      (tail),
      .count     (count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
      end else begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            if (complete_valid && entries[i].valid &&
                entries[i].phys_rd == complete_phys_reg)
               entries[i].done <= 1'b1;
            if (do_retire && head == PTR_W'(i))
               entries[i].valid <= 1'b0;
            if (do_alloc && tail == PTR_W'(i))
               entries[i] <= '{valid:       1'b1,
                               done:        1'b0,
                               phys_rd:     alloc_phys_rd,
                               old_phys_rd: alloc_old_phys_rd,
                               arch_rd:     alloc_arch_rd};
         end
      end
   end

   // Retire payload holds its last value while retire_valid is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_valid    <= 1'b0;
         retire_phys_reg <= '0;
         retire_arch_reg <= '0;
      end else begin
         retire_valid <= do_retire;
         if (do_retire) begin
            retire_phys_reg <= entries[head].old_phys_rd;
            retire_arch_reg <= entries[head].arch_rd;
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_reorder_buffer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       alloc_valid = 1'b0;
   logic [5:0] alloc_phys_rd = '0;
   logic [5:0] alloc_old_phys_rd = '0;
   logic [4:0] alloc_arch_rd = '0;
   logic       alloc_ready;
   logic [3:0] alloc_tag;
   logic       complete_valid = 1'b0;
   logic [5:0] complete_phys_reg = '0;
   logic       retire_valid;
   logic [5:0] retire_phys_reg;
   logic [4:0] retire_arch_reg;
   logic       rob_empty;
   logic [4:0] rob_count;

   int vectors = 0;
   int miscompares = 0;

   reorder_buffer dut (
      .clk               (clk),
      .reset             (reset),
      .alloc_valid       (alloc_valid),
      .alloc_phys_rd     (alloc_phys_rd),
      .alloc_old_phys_rd (alloc_old_phys_rd),
      .alloc_arch_rd     (alloc_arch_rd),
      .alloc_ready       (alloc_ready),
      .alloc_tag         (alloc_tag),
      .complete_valid    (complete_valid),
      .complete_phys_reg (complete_phys_reg),
      .retire_valid      (retire_valid),
      .retire_phys_reg   (retire_phys_reg),
      .retire_arch_reg   (retire_arch_reg),
      .rob_empty         (rob_empty),
      .rob_count         (rob_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_alloc(input logic v, input logic [5:0] p, input logic [5:0] o, input logic [4:0] a);
      alloc_valid       = v;
      alloc_phys_rd     = p;
      alloc_old_phys_rd = o;
      alloc_arch_rd     = a;
   endtask

   task automatic drive_cmp(input logic v, input logic [5:0] p);
      complete_valid    = v;
      complete_phys_reg = p;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_count", 32'(rob_count), 0);
      chk("rst_empty", 32'(rob_empty), 1);
      chk("rst_ready", 32'(alloc_ready), 1);
      chk("rst_tag", 32'(alloc_tag), 0);
      chk("rst_rv", 32'(retire_valid), 0);
      chk("rst_rphys", 32'(retire_phys_reg), 0);
      chk("rst_rarch", 32'(retire_arch_reg), 0);
      reset = 1'b0;

      // Single alloc / complete / retire; done is registered so retire lags by one
      drive_alloc(1'b1, 6'd32, 6'd5, 5'd5);
      tick();
      chk("s_count1", 32'(rob_count), 1);
      chk("s_tag1", 32'(alloc_tag), 1);
      chk("s_empty0", 32'(rob_empty), 0);
      drive_alloc(1'b0, 6'd0, 6'd0, 5'd0);
      drive_cmp(1'b1, 6'd32);
      tick();
      chk("s_rv_early", 32'(retire_valid), 0);
      drive_cmp(1'b0, 6'd0);
      tick();
      chk("s_rv", 32'(retire_valid), 1);
      chk("s_rphys", 32'(retire_phys_reg), 5);
      chk("s_rarch", 32'(retire_arch_reg), 5);
      chk("s_count0", 32'(rob_count), 0);
      chk("s_empty1", 32'(rob_empty), 1);
      tick();
      chk("s_rv_drop", 32'(retire_valid), 0);
      chk("s_rphys_hold", 32'(retire_phys_reg), 5);

      // Out-of-order completion, in-order retirement
      drive_alloc(1'b1, 6'd32, 6'd10, 5'd1); tick();
      drive_alloc(1'b1, 6'd33, 6'd11, 5'd2); tick();
      drive_alloc(1'b1, 6'd34, 6'd12, 5'd3); tick();
      drive_alloc(1'b0, 6'd0, 6'd0, 5'd0);
      chk("o_count3", 32'(rob_count), 3);
      drive_cmp(1'b1, 6'd34); tick();
      chk("o_rv_a", 32'(retire_valid), 0);
      drive_cmp(1'b1, 6'd50); tick();
      chk("o_rv_absent", 32'(retire_valid), 0);
      drive_cmp(1'b1, 6'd33); tick();
      chk("o_rv_b", 32'(retire_valid), 0);
      drive_cmp(1'b1, 6'd32); tick();
      chk("o_rv_c", 32'(retire_valid), 0);
      drive_cmp(1'b0, 6'd0); tick();
      chk("o_rv1", 32'(retire_valid), 1);
      chk("o_rphys1", 32'(retire_phys_reg), 10);
      chk("o_rarch1", 32'(retire_arch_reg), 1);
      tick();
      chk("o_rv2", 32'(retire_valid), 1);
      chk("o_rphys2", 32'(retire_phys_reg), 11);
      chk("o_rarch2", 32'(retire_arch_reg), 2);
      tick();
      chk("o_rv3", 32'(retire_valid), 1);
      chk("o_rphys3", 32'(retire_phys_reg), 12);
      chk("o_rarch3", 32'(retire_arch_reg), 3);
      chk("o_count0", 32'(rob_count), 0);
      tick();
      chk("o_rv_idle", 32'(retire_valid), 0);

      // Steady-state stream of 20 starting at index 4: pointers wrap past 15
      for (int j = 0; j <= 22; j++) begin
         if (j < 20) drive_alloc(1'b1, 6'(j), 6'(40 + j), 5'(j));
         else        drive_alloc(1'b0, 6'd0, 6'd0, 5'd0);
         if (j >= 1 && j <= 20) drive_cmp(1'b1, 6'(j - 1));
         else                   drive_cmp(1'b0, 6'd0);
         tick();
         if (j >= 2 && j <= 21) begin
            chk("w_rv", 32'(retire_valid), 1);
            chk("w_rphys", 32'(retire_phys_reg), 32'(40 + j - 2));
            chk("w_rarch", 32'(retire_arch_reg), 32'(j - 2));
         end else begin
            chk("w_rv_idle", 32'(retire_valid), 0);
         end
      end
      chk("w_count", 32'(rob_count), 0);
      chk("w_tag", 32'(alloc_tag), 8);

      // Fill to 16; a 17th request is dropped
      for (int i = 0; i < 16; i++) begin
         drive_alloc(1'b1, 6'(i), 6'(16 + i), 5'(i));
         tick();
      end
      chk("f_count16", 32'(rob_count), 16);
      chk("f_ready0", 32'(alloc_ready), 0);
      chk("f_tag", 32'(alloc_tag), 8);
      drive_alloc(1'b1, 6'd20, 6'd21, 5'd22);
      tick();
      chk("f_drop_count", 32'(rob_count), 16);
      chk("f_drop_tag", 32'(alloc_tag), 8);

      // Full with head done and alloc held: retire wins, alloc dropped
      drive_cmp(1'b1, 6'd0);
      tick();
      chk("f_count_hold", 32'(rob_count), 16);
      drive_cmp(1'b0, 6'd0);
      tick();
      chk("f_rv", 32'(retire_valid), 1);
      chk("f_rphys", 32'(retire_phys_reg), 16);
      chk("f_rarch", 32'(retire_arch_reg), 0);
      chk("f_count15", 32'(rob_count), 15);
      chk("f_tag_same", 32'(alloc_tag), 8);
      chk("f_ready1", 32'(alloc_ready), 1);
      drive_alloc(1'b0, 6'd0, 6'd0, 5'd0);
      drive_cmp(1'b1, 6'd0);
      tick();
      drive_cmp(1'b0, 6'd0);
      tick();
      chk("f_stale_rv", 32'(retire_valid), 0);
      chk("f_stale_count", 32'(rob_count), 15);

      // Mid-operation reset with 5 pending, 2 completed
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive_alloc(1'b1, 6'(i), 6'(20 + i), 5'(i));
         tick();
      end
      drive_alloc(1'b0, 6'd0, 6'd0, 5'd0);
      drive_cmp(1'b1, 6'd3); tick();
      drive_cmp(1'b1, 6'd4); tick();
      drive_cmp(1'b0, 6'd0);
      chk("r_count5", 32'(rob_count), 5);
      #2;
      reset = 1'b1;
      #1;
      chk("r_count0", 32'(rob_count), 0);
      chk("r_empty", 32'(rob_empty), 1);
      chk("r_tag", 32'(alloc_tag), 0);
      chk("r_rv", 32'(retire_valid), 0);
      chk("r_rphys", 32'(retire_phys_reg), 0);
      tick();
      reset = 1'b0;
      drive_cmp(1'b1, 6'd3); tick();
      drive_cmp(1'b0, 6'd0); tick();
      tick();
      chk("r_no_rv", 32'(retire_valid), 0);
      chk("r_still_empty", 32'(rob_empty), 1);
      drive_alloc(1'b1, 6'd7, 6'd9, 5'd4); tick();
      drive_alloc(1'b0, 6'd0, 6'd0, 5'd0);
      drive_cmp(1'b1, 6'd7); tick();
      drive_cmp(1'b0, 6'd0); tick();
      chk("r_fresh_rv", 32'(retire_valid), 1);
      chk("r_fresh_rphys", 32'(retire_phys_reg), 9);
      chk("r_fresh_rarch", 32'(retire_arch_reg), 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
